// File: rtl/ahbl_to_apb4_mux.sv
// AHB-Lite slave to N-slave APB4 master bridge: decoded PSEL, PSTRB/PPROT
// generation, PREADY timeout reported as an AHB error, per-transfer hart ID.
module ahbl_to_apb4_mux #(
  parameter int W_HADDR  = 32,
  parameter int W_PADDR  = 16,
  parameter int W_DATA   = 32,
  parameter int N_SLAVES = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       ahbls_hready,
  output logic                       ahbls_hready_resp,
  output logic                       ahbls_hresp,
  input  logic [W_HADDR-1:0]         ahbls_haddr,
  input  logic                       ahbls_hwrite,
  input  logic [1:0]                 ahbls_htrans,
  input  logic [2:0]                 ahbls_hsize,
  input  logic [3:0]                 ahbls_hprot,
  input  logic [W_DATA-1:0]          ahbls_hwdata,
  output logic [W_DATA-1:0]          ahbls_hrdata,
  input  logic [W_DATA-1:0]          ahbls_hartid,

  output logic [W_PADDR-1:0]         apbm_paddr,
  output logic [N_SLAVES-1:0]        apbm_psel,
  output logic                       apbm_penable,
  output logic                       apbm_pwrite,
  output logic [W_DATA-1:0]          apbm_pwdata,
  output logic [W_DATA/8-1:0]        apbm_pstrb,
  output logic [2:0]                 apbm_pprot,
  output logic [W_DATA-1:0]          apbm_phartid,
  input  logic [N_SLAVES-1:0]        apbm_pready,
  input  logic [N_SLAVES*W_DATA-1:0] apbm_prdata,
  input  logic [N_SLAVES-1:0]        apbm_pslverr
);

  localparam int W_SLVSEL = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int W_STRB   = W_DATA / 8;
  localparam int W_OFF    = $clog2(W_STRB);
  localparam int W_CNT    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W_CNT-1:0]    CNT_LAST = W_CNT'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [W_SLVSEL:0]   N_SLV    = (W_SLVSEL + 1)'(N_SLAVES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR0,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR0,
    ST_ERR1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [W_SLVSEL-1:0]  idx;
  logic [W_SLVSEL-1:0]  cap_idx;
  logic                 hwrite_q;
  logic [W_CNT-1:0]     cnt;
  logic                 cap_state;
  logic                 cap;
  logic [W_STRB-1:0]    strb_nxt;
  logic [W_OFF-1:0]     byte_off;
  logic [N_SLAVES-1:0]  psel_dec;
  logic                 sel_ready;
  logic                 sel_err;
  logic [W_DATA-1:0]    sel_rdata;
  logic                 timed_out;
  logic                 unused_bits;

  assign unused_bits = ^{ahbls_haddr[W_HADDR-1:W_PADDR], ahbls_hprot[3:2]};

  assign cap_idx   = ahbls_haddr[W_PADDR-1 -: W_SLVSEL];
  assign byte_off  = ahbls_haddr[W_OFF-1:0];
  assign cap_state = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR1);
  assign cap       = cap_state && ahbls_htrans[1] && ahbls_hready;
  assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // A byte lane is enabled when it agrees with the address on every bit above
  // the transfer size; this yields the naturally aligned 2^hsize-byte mask.
  always_comb begin
    strb_nxt = '0;
    for (int unsigned i = 0; i < W_STRB; i++) begin
      strb_nxt[i] = ((W_OFF'(i) ^ byte_off) >> ahbls_hsize) == '0;
    end
  end

  // Only the latched slave's handshake is ever looked at.
  always_comb begin
    psel_dec  = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (idx == W_SLVSEL'(i)) begin
        psel_dec[i] = 1'b1;
        sel_ready   = apbm_pready[i];
        sel_err     = apbm_pslverr[i];
        sel_rdata   = apbm_prdata[i*W_DATA +: W_DATA];
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    ahbls_hready_resp = 1'b0;
    ahbls_hresp       = 1'b0;
    apbm_psel         = '0;
    apbm_penable      = 1'b0;
    apbm_pwrite       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR1: begin
        ahbls_hready_resp = 1'b1;
        ahbls_hresp       = (state == ST_ERR1);
        if (!cap)                      state_nxt = ST_IDLE;
        else if ({1'b0, cap_idx} >= N_SLV) state_nxt = ST_ERR0;
        else if (ahbls_hwrite)         state_nxt = ST_WR0;
        else                           state_nxt = ST_SETUP;
      end
      ST_WR0: state_nxt = ST_SETUP;
      ST_SETUP: begin
        apbm_psel   = psel_dec;
        apbm_pwrite = hwrite_q;
        state_nxt   = ST_ACCESS;
      end
      ST_ACCESS: begin
        apbm_psel    = psel_dec;
        apbm_penable = 1'b1;
        apbm_pwrite  = hwrite_q;
        // Completion outranks an expiring timeout in the same cycle.
        if (sel_ready)      state_nxt = sel_err ? ST_ERR0 : ST_DONE;
        else if (timed_out) state_nxt = ST_ERR0;
      end
      ST_ERR0: begin
        ahbls_hresp = 1'b1;
        state_nxt   = ST_ERR1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      apbm_paddr   <= '0;
      apbm_pwdata  <= '0;
      apbm_pstrb   <= '0;
      apbm_pprot   <= '0;
      apbm_phartid <= '0;
      ahbls_hrdata <= '0;
      idx          <= '0;
      hwrite_q     <= 1'b0;
      cnt          <= '0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        apbm_paddr   <= ahbls_haddr[W_PADDR-1:0];
        idx          <= cap_idx;
        hwrite_q     <= ahbls_hwrite;
        apbm_phartid <= ahbls_hartid;
        apbm_pprot   <= {~ahbls_hprot[0], 1'b0, ahbls_hprot[1]};
        apbm_pstrb   <= ahbls_hwrite ? strb_nxt : '0;
      end
      if (state == ST_WR0) apbm_pwdata <= ahbls_hwdata;
      if (state == ST_SETUP)                    cnt <= '0;
      else if (state == ST_ACCESS && !sel_ready) cnt <= cnt + 1'b1;
      if (state == ST_ACCESS && sel_ready && !hwrite_q) ahbls_hrdata <= sel_rdata;
    end
  end

endmodule

// File: tb/tb_ahbl_to_apb4_mux.sv
// Directed bench for ahbl_to_apb4_mux: a vector table of single transfers
// plus hand-written error, timeout, decode and reset sequences.
module tb_ahbl_to_apb4_mux;

  localparam int W_HADDR = 32;
  localparam int W_PADDR = 16;
  localparam int W_DATA  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        hready;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [1:0]  htrans3;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hartid;

  logic        hready_resp, hresp, penable, pwrite;
  logic [31:0] hrdata, pwdata, phartid;
  logic [15:0] paddr;
  logic [3:0]  psel, pstrb, pready, pslverr;
  logic [2:0]  pprot;
  logic [127:0] prdata;

  logic        hready_resp3, hresp3, penable3, pwrite3;
  logic [31:0] hrdata3, pwdata3, phartid3;
  logic [15:0] paddr3;
  logic [2:0]  psel3, pready3, pslverr3, pprot3;
  logic [3:0]  pstrb3;
  logic [95:0] prdata3;

  ahbl_to_apb4_mux #(.W_HADDR(W_HADDR), .W_PADDR(W_PADDR), .W_DATA(W_DATA),
                     .N_SLAVES(4), .TIMEOUT(5)) dut4 (
    .clk(clk), .rst(rst),
    .ahbls_hready(hready), .ahbls_hready_resp(hready_resp), .ahbls_hresp(hresp),
    .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans),
    .ahbls_hsize(hsize), .ahbls_hprot(hprot), .ahbls_hwdata(hwdata),
    .ahbls_hrdata(hrdata), .ahbls_hartid(hartid),
    .apbm_paddr(paddr), .apbm_psel(psel), .apbm_penable(penable), .apbm_pwrite(pwrite),
    .apbm_pwdata(pwdata), .apbm_pstrb(pstrb), .apbm_pprot(pprot), .apbm_phartid(phartid),
    .apbm_pready(pready), .apbm_prdata(prdata), .apbm_pslverr(pslverr)
  );

  ahbl_to_apb4_mux #(.W_HADDR(W_HADDR), .W_PADDR(W_PADDR), .W_DATA(W_DATA),
                     .N_SLAVES(3), .TIMEOUT(255)) dut3 (
    .clk(clk), .rst(rst),
    .ahbls_hready(hready), .ahbls_hready_resp(hready_resp3), .ahbls_hresp(hresp3),
    .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans3),
    .ahbls_hsize(hsize), .ahbls_hprot(hprot), .ahbls_hwdata(hwdata),
    .ahbls_hrdata(hrdata3), .ahbls_hartid(hartid),
    .apbm_paddr(paddr3), .apbm_psel(psel3), .apbm_penable(penable3), .apbm_pwrite(pwrite3),
    .apbm_pwdata(pwdata3), .apbm_pstrb(pstrb3), .apbm_pprot(pprot3), .apbm_phartid(phartid3),
    .apbm_pready(pready3), .apbm_prdata(prdata3), .apbm_pslverr(pslverr3)
  );

  localparam logic [127:0] PRDATA_DEF = {32'h4444_3333, 32'hDEAD_BEEF, 32'h2222_1111, 32'h1111_0000};

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hartid;
    logic [3:0]  e_psel;
    logic [3:0]  e_pstrb;
    logic [2:0]  e_pprot;
    logic [15:0] e_paddr;
    logic [31:0] e_rdata;
    int          e_lat;
  } vec_t;

  vec_t vecs[10];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Address phase in the current cycle; afterwards the address-phase inputs
  // are scrambled so only captured values can satisfy later checks.
  task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                            input logic [3:0] pr, input logic [31:0] wd,
                            input logic [31:0] hid, input bit to3);
    haddr = a; hwrite = wr; hsize = sz; hprot = pr; hartid = hid;
    hwdata = 32'h5A5A_5A5A;
    if (to3) htrans3 = 2'b10;
    else     htrans  = 2'b10;
    tick;
    htrans = 2'b00; htrans3 = 2'b00;
    hwdata = wd; haddr = ~a; hartid = ~hid; hprot = ~pr; hsize = 3'd0;
  endtask

  task automatic xfer(input vec_t v);
    int cyc, n_setup, n_acc;
    addr_phase(v.wr, v.haddr, v.hsize, v.hprot, v.hwdata, v.hartid, 1'b0);
    cyc = 1; n_setup = 0; n_acc = 0;
    while (1) begin
      if (psel != 4'b0000 && !penable) begin
        n_setup++;
        chk({v.name, "_psel"},    psel,    v.e_psel);
        chk({v.name, "_paddr"},   paddr,   v.e_paddr);
        chk({v.name, "_pstrb"},   pstrb,   v.e_pstrb);
        chk({v.name, "_pprot"},   pprot,   v.e_pprot);
        chk({v.name, "_pwrite"},  pwrite,  v.wr);
        chk({v.name, "_phartid"}, phartid, v.hartid);
        if (v.wr) chk({v.name, "_pwdata"}, pwdata, v.hwdata);
      end
      if (penable) n_acc++;
      if (hready_resp || cyc >= 20) break;
      tick;
      cyc++;
    end
    chk({v.name, "_latency"}, cyc, v.e_lat);
    chk({v.name, "_setup_cycles"}, n_setup, 1);
    chk({v.name, "_access_cycles"}, n_acc, 1);
    chk({v.name, "_hresp"}, hresp, 1'b0);
    if (!v.wr) chk({v.name, "_hrdata"}, hrdata, v.e_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n;

    vecs[0] = '{"rd_s2",     1'b0, 32'h0000_8004, 3'd2, 4'b0011, 32'h0,         32'h7, 4'b0100, 4'b0000, 3'b001, 16'h8004, 32'hDEAD_BEEF, 3};
    vecs[1] = '{"wr_b3",     1'b1, 32'h0000_0003, 3'd0, 4'b0001, 32'hAA00_0000, 32'h1, 4'b0001, 4'b1000, 3'b000, 16'h0003, 32'h0,         4};
    vecs[2] = '{"wr_h2",     1'b1, 32'h0000_4002, 3'd1, 4'b0000, 32'h1234_0000, 32'h2, 4'b0010, 4'b1100, 3'b100, 16'h4002, 32'h0,         4};
    vecs[3] = '{"wr_w_s3",   1'b1, 32'h0000_C000, 3'd2, 4'b0010, 32'hCAFE_F00D, 32'h3, 4'b1000, 4'b1111, 3'b101, 16'hC000, 32'h0,         4};
    vecs[4] = '{"rd_s1",     1'b0, 32'h1234_4010, 3'd2, 4'b0011, 32'h0,         32'h4, 4'b0010, 4'b0000, 3'b001, 16'h4010, 32'h2222_1111, 3};
    vecs[5] = '{"wr_b1",     1'b1, 32'h0000_0001, 3'd0, 4'b0011, 32'h0000_BB00, 32'h5, 4'b0001, 4'b0010, 3'b001, 16'h0001, 32'h0,         4};
    vecs[6] = '{"wr_w_unal", 1'b1, 32'h0000_C001, 3'd2, 4'b0001, 32'h0BAD_F00D, 32'h6, 4'b1000, 4'b1111, 3'b000, 16'hC001, 32'h0,         4};
    vecs[7] = '{"rd_s0",     1'b0, 32'h0000_0000, 3'd2, 4'b0000, 32'h0,         32'h8, 4'b0001, 4'b0000, 3'b100, 16'h0000, 32'h1111_0000, 3};
    vecs[8] = '{"rd_s3",     1'b0, 32'hFFFF_C008, 3'd2, 4'b0010, 32'h0,         32'h9, 4'b1000, 4'b0000, 3'b101, 16'hC008, 32'h4444_3333, 3};
    vecs[9] = '{"wr_h0",     1'b1, 32'h0000_8000, 3'd1, 4'b0011, 32'h0000_BEEF, 32'hA, 4'b0100, 4'b0011, 3'b001, 16'h8000, 32'h0,         4};

    rst = 1'b1; hready = 1'b1; haddr = '0; hwrite = 1'b0; htrans = 2'b00; htrans3 = 2'b00;
    hsize = 3'd0; hprot = 4'b0; hwdata = '0; hartid = '0;
    pready = 4'b1111; pslverr = 4'b0000; prdata = PRDATA_DEF;
    pready3 = 3'b111; pslverr3 = 3'b000; prdata3 = {32'h0303_0202, 32'h0202_0101, 32'h0101_0000};
    @(negedge clk);
    tick;
    chk("rst_hready_resp", hready_resp, 1'b1);
    chk("rst_hresp",       hresp,       1'b0);
    chk("rst_psel",        psel,        4'b0000);
    chk("rst_penable",     penable,     1'b0);
    chk("rst_pwrite",      pwrite,      1'b0);
    chk("rst_regs",        {paddr, pstrb, pprot, pwdata}, '0);
    chk("rst_regs2",       {phartid, hrdata}, '0);
    chk("rst3_outs",       {hready_resp3, hresp3, psel3, penable3, pwrite3}, 7'b1000000);
    chk("rst3_regs",       {paddr3, pstrb3, pprot3, pwdata3}, '0);
    chk("rst3_regs2",      {phartid3, hrdata3}, '0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 10; i++) xfer(vecs[i]);

    // Capture attempt with bus hready low in DONE is ignored.
    htrans = 2'b10; hready = 1'b0; haddr = 32'h0000_8000; hwrite = 1'b0;
    tick;
    chk("hready0_psel", psel, 4'b0000);
    chk("hready0_resp", hready_resp, 1'b1);
    htrans = 2'b00; hready = 1'b1;
    tick;
    chk("hready0_psel_after", psel, 4'b0000);

    // BUSY transfers are not captured.
    htrans = 2'b01; haddr = 32'h0000_8000;
    tick;
    chk("busy_psel", psel, 4'b0000);
    chk("busy_resp", hready_resp, 1'b1);
    tick;
    chk("busy_psel2", psel, 4'b0000);
    htrans = 2'b00;
    tick;

    // Handshakes of non-selected slaves must not matter.
    pready = 4'b0100; pslverr = 4'b1011;
    xfer(vecs[0]);
    pready = 4'b1111; pslverr = 4'b0000;
    tick;

    // PREADY held low: abandoned after 5 ACCESS cycles, two-cycle error.
    pready = 4'b1101;
    addr_phase(1'b0, 32'h0000_4000, 3'd2, 4'b0011, 32'h0, 32'h9, 1'b0);
    chk("to_setup_psel", psel, 4'b0010);
    tick;
    n = 0;
    while (penable && n < 20) begin
      n++;
      chk("to_access_psel", psel, 4'b0010);
      tick;
    end
    chk("to_access_cycles", n, 5);
    chk("to_err0_psel", psel, 4'b0000);
    chk("to_err0_penable", penable, 1'b0);
    chk("to_err0_resp", {hready_resp, hresp}, 2'b01);
    tick;
    chk("to_err1_resp", {hready_resp, hresp}, 2'b11);
    chk("to_err1_psel", psel, 4'b0000);
    repeat (3) tick;
    pready = 4'b1111;
    chk("to_idle_resp", {hready_resp, hresp}, 2'b10);

    // PREADY arriving on the cycle the timeout expires completes normally.
    pready = 4'b1101;
    prdata[32 +: 32] = 32'h1357_9BDF;
    addr_phase(1'b0, 32'h0000_4000, 3'd2, 4'b0011, 32'h0, 32'hB, 1'b0);
    tick;
    repeat (4) tick;
    chk("race_penable", penable, 1'b1);
    pready = 4'b1111;
    tick;
    chk("race_resp", {hready_resp, hresp}, 2'b10);
    chk("race_hrdata", hrdata, 32'h1357_9BDF);
    prdata = PRDATA_DEF;
    tick;

    // PSLVERR on a write, then a read captured in ERR1.
    pslverr = 4'b0001;
    addr_phase(1'b1, 32'h0000_0010, 3'd2, 4'b0011, 32'h0102_0304, 32'hC, 1'b0);
    cyc = 1;
    while (!hresp && cyc < 20) begin
      tick;
      cyc++;
    end
    chk("slverr_cycles", cyc, 4);
    chk("slverr_err0", {hready_resp, hresp}, 2'b01);
    pslverr = 4'b0000;
    tick;
    chk("slverr_err1", {hready_resp, hresp}, 2'b11);
    xfer(vecs[4]);
    tick;

    // N_SLAVES=3: index 3 decode-errors without an APB cycle.
    addr_phase(1'b0, 32'h0000_C000, 3'd2, 4'b0011, 32'h0, 32'hD, 1'b1);
    chk("dec_err0_psel", psel3, 3'b000);
    chk("dec_err0_resp", {hready_resp3, hresp3}, 2'b01);
    chk("dec_dut4_idle", psel, 4'b0000);
    tick;
    chk("dec_err1_psel", psel3, 3'b000);
    chk("dec_err1_resp", {hready_resp3, hresp3}, 2'b11);
    tick;
    chk("dec_idle_resp", {hready_resp3, hresp3}, 2'b10);

    addr_phase(1'b0, 32'h0000_8008, 3'd2, 4'b0011, 32'h0, 32'hE, 1'b1);
    chk("n3_setup_psel", psel3, 3'b100);
    chk("n3_setup_paddr", paddr3, 16'h8008);
    cyc = 1;
    while (!hready_resp3 && cyc < 20) begin
      tick;
      cyc++;
    end
    chk("n3_latency", cyc, 3);
    chk("n3_hrdata", hrdata3, 32'h0303_0202);
    tick;

    // Reset in the middle of ACCESS.
    pready = 4'b1101;
    addr_phase(1'b0, 32'h0000_4000, 3'd2, 4'b0000, 32'h0, 32'h77, 1'b0);
    tick;
    chk("rstmid_penable", penable, 1'b1);
    rst = 1'b1;
    tick;
    chk("rstmid_psel", psel, 4'b0000);
    chk("rstmid_penable0", penable, 1'b0);
    chk("rstmid_resp", {hready_resp, hresp}, 2'b10);
    chk("rstmid_regs", {paddr, pstrb, pprot, pwdata}, '0);
    chk("rstmid_regs2", {phartid, hrdata}, '0);
    rst = 1'b0;
    pready = 4'b1111;
    tick;
    xfer(vecs[0]);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
